// File: rtl/udp_pkg.sv
// udp_pkg: shared types for the UDP receive-path frame reader.
//   fr_state_e : framing FSM states
//   beat_t     : one beat as it travels through the skid buffer
//   DATA_WIDTH : default byte-lane width, matches the framed FIFO
package udp_pkg;

  localparam int DATA_WIDTH  = 8;
  // Length field wide enough for any MAX_FRAME_LEN up to 65535; the reader
  // only drives/uses its low LEN_WIDTH bits.
  localparam int LEN_FIELD_W = 16;

  typedef enum logic [0:0] {
    FR_IDLE     = 1'b0,
    FR_IN_FRAME = 1'b1
  } fr_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic                   sof;
    logic                   eof;
    logic [LEN_FIELD_W-1:0] len;
  } beat_t;

endpackage

// File: rtl/udp_frame_reader_if.sv
// udp_frame_reader_if: valid/ready byte stream from the frame reader to the
// UDP parser.
//   out_valid/out_ready : handshake (master drives valid, slave drives ready)
//   out_data            : beat data
//   out_sof/out_eof     : frame tags
//   out_len             : beats so far in frame, meaningful with out_eof
interface udp_frame_reader_if #(
  parameter int DATA_WIDTH = udp_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = 12
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sof;
  logic                  out_eof;
  logic [LEN_WIDTH-1:0]  out_len;

  modport master (output out_valid, out_data, out_sof, out_eof, out_len,
                  input  out_ready);
  modport slave  (input  out_valid, out_data, out_sof, out_eof, out_len,
                  output out_ready);
endinterface

// File: rtl/udp_skid_buf2.sv
// udp_skid_buf2: 2-entry valid/ready register buffer.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : write side handshake
//   in_data             : W-bit payload in
//   out_valid/out_ready : read side handshake
//   out_data            : W-bit payload out, straight from the head register
//   count               : occupancy 0..2
// out_valid/out_data depend only on registers, so there is no path from
// out_ready to them.
module udp_skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] head_q, tail_q;
  logic [1:0]   cnt_q;
  logic         push, pop;

  assign pop       = out_valid && out_ready;
  assign in_ready  = (cnt_q != 2'd2) || pop;
  assign push      = in_valid && in_ready;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign count     = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= in_data;
          else               tail_q <= in_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: occupancy unchanged, order kept.
          if (cnt_q == 2'd1) begin
            head_q <= in_data;
          end else begin
            head_q <= tail_q;
            tail_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/udp_frame_reader.sv
// udp_frame_reader: drains the framed byte FIFO and presents a valid/ready
// stream to the UDP parser.
//   rd_clk, reset        : FIFO read clock, synchronous active-high reset
//   fifo_rd_en           : read strobe; data returns one cycle later
//   fifo_dout/sof/eof    : returned beat and tags
//   fifo_empty           : FIFO empty
//   out_if               : output stream (master side)
//   err_no_sof           : pulse, beat dropped outside a frame
//   err_sof_in_frame     : pulse, sof arrived inside an open frame
//   err_too_long         : pulse, first beat past MAX_FRAME_LEN forwarded
//   frame_count          : completed frames (eof handshaken), wraps
module udp_frame_reader #(
  parameter int DATA_WIDTH    = udp_pkg::DATA_WIDTH,
  parameter int MAX_FRAME_LEN = 2048,
  parameter int LEN_WIDTH     = $clog2(MAX_FRAME_LEN + 1)
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_sof,
  input  logic                  fifo_eof,
  input  logic                  fifo_empty,
  udp_frame_reader_if.master    out_if,
  output logic                  err_no_sof,
  output logic                  err_sof_in_frame,
  output logic                  err_too_long,
  output logic [15:0]           frame_count
);
  import udp_pkg::*;

  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_FRAME_LEN);

  fr_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 tl_seen_q, tl_seen_d;
  logic                 inflight_q;
  logic                 fwd, ns_d, sif_d, tl_d;

  beat_t                beat_in, beat_out;
  logic                 sk_valid, sk_in_ready, pop;
  logic [1:0]           sk_count, used;

  // Read credit. A beat leaving the skid this cycle frees its slot now, so
  // the FIFO can be read every cycle while downstream keeps up.
  assign pop        = sk_valid && out_if.out_ready;
  assign used       = sk_count - {1'b0, pop} + {1'b0, inflight_q};
  assign fifo_rd_en = !fifo_empty && (used < 2'd2) && !reset;

  // Framing FSM, evaluated on the returning beat.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    tl_seen_d = tl_seen_q;
    fwd       = 1'b0;
    ns_d      = 1'b0;
    sif_d     = 1'b0;
    tl_d      = 1'b0;
    if (inflight_q) begin
      if (fifo_sof) begin
        // sof always opens a new frame; the old one is abandoned without eof.
        fwd       = 1'b1;
        len_d     = LEN_WIDTH'(1);
        tl_seen_d = 1'b0;
        sif_d     = (state_q == FR_IN_FRAME);
        state_d   = fifo_eof ? FR_IDLE : FR_IN_FRAME;
      end else if (state_q == FR_IN_FRAME) begin
        fwd = 1'b1;
        if (len_q == LEN_MAX) begin
          tl_d      = !tl_seen_q;
          tl_seen_d = 1'b1;
        end else begin
          len_d = len_q + LEN_WIDTH'(1);
        end
        if (fifo_eof) state_d = FR_IDLE;
      end else begin
        ns_d = 1'b1;
      end
    end
  end

  always_comb begin
    beat_in = '{data: fifo_dout, sof: fifo_sof, eof: fifo_eof,
                len: LEN_FIELD_W'(len_d)};
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q          <= FR_IDLE;
      len_q            <= '0;
      tl_seen_q        <= 1'b0;
      inflight_q       <= 1'b0;
      err_no_sof       <= 1'b0;
      err_sof_in_frame <= 1'b0;
      err_too_long     <= 1'b0;
      frame_count      <= '0;
    end else begin
      state_q          <= state_d;
      len_q            <= len_d;
      tl_seen_q        <= tl_seen_d;
      inflight_q       <= fifo_rd_en;
      err_no_sof       <= ns_d;
      err_sof_in_frame <= sif_d;
      err_too_long     <= tl_d;
      if (pop && beat_out.eof) frame_count <= frame_count + 16'd1;
    end
  end

  udp_skid_buf2 #(.W($bits(beat_t))) u_skid (
    .clk       (rd_clk),
    .reset     (reset),
    .in_valid  (fwd),
    .in_ready  (sk_in_ready),
    .in_data   (beat_in),
    .out_valid (sk_valid),
    .out_ready (out_if.out_ready),
    .out_data  (beat_out),
    .count     (sk_count)
  );

  // Credit accounting guarantees space; in_ready is never low when fwd is.
  logic unused_push_ok;
  assign unused_push_ok = sk_in_ready & (&{1'b0, beat_out.len});

  assign out_if.out_valid = sk_valid;
  assign out_if.out_data  = beat_out.data;
  assign out_if.out_sof   = beat_out.sof;
  assign out_if.out_eof   = beat_out.eof;
  assign out_if.out_len   = beat_out.len[LEN_WIDTH-1:0];

endmodule

// File: tb/tb_udp_frame_reader.sv
`timescale 1ns/1ps
module tb_udp_frame_reader;
  localparam int DW    = 8;
  localparam int MAX_A = 2048;
  localparam int MAX_B = 4;
  localparam int LW_A  = $clog2(MAX_A + 1);
  localparam int LW_B  = $clog2(MAX_B + 1);

  logic rd_clk = 1'b0;
  logic reset = 1'b1;
  logic out_ready = 1'b0;
  always #5 rd_clk = ~rd_clk;

  logic          fifo_rd_en_a, fifo_rd_en_b;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_sof = 1'b0, fifo_eof = 1'b0;
  logic          fifo_empty;
  logic          err_no_sof_a, err_sof_in_frame_a, err_too_long_a;
  logic          err_no_sof_b, err_sof_in_frame_b, err_too_long_b;
  logic [15:0]   frame_count_a, frame_count_b;

  udp_frame_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW_A)) a_if ();
  udp_frame_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW_B)) b_if ();
  assign a_if.out_ready = out_ready;
  assign b_if.out_ready = out_ready;

  // Both readers see the same FIFO and the same ready, so their read timing
  // is identical; only lengths and too-long pulses differ.
  udp_frame_reader #(.DATA_WIDTH(DW), .MAX_FRAME_LEN(MAX_A)) dut_a (
    .rd_clk(rd_clk), .reset(reset), .fifo_rd_en(fifo_rd_en_a),
    .fifo_dout(fifo_dout), .fifo_sof(fifo_sof), .fifo_eof(fifo_eof),
    .fifo_empty(fifo_empty), .out_if(a_if),
    .err_no_sof(err_no_sof_a), .err_sof_in_frame(err_sof_in_frame_a),
    .err_too_long(err_too_long_a), .frame_count(frame_count_a));

  udp_frame_reader #(.DATA_WIDTH(DW), .MAX_FRAME_LEN(MAX_B)) dut_b (
    .rd_clk(rd_clk), .reset(reset), .fifo_rd_en(fifo_rd_en_b),
    .fifo_dout(fifo_dout), .fifo_sof(fifo_sof), .fifo_eof(fifo_eof),
    .fifo_empty(fifo_empty), .out_if(b_if),
    .err_no_sof(err_no_sof_b), .err_sof_in_frame(err_sof_in_frame_b),
    .err_too_long(err_too_long_b), .frame_count(frame_count_b));

  // FIFO model: one-cycle read latency, flushed by reset.
  typedef struct packed { logic [7:0] d; logic sof; logic eof; logic drop; } fent_t;
  fent_t fmem [0:1023];
  int    wr_ptr = 0;
  int    rd_ptr = 0;
  logic  ret_vld = 1'b0, ret_drop = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge rd_clk) begin
    if (reset) begin
      rd_ptr  <= wr_ptr;
      ret_vld <= 1'b0;
      ret_drop <= 1'b0;
    end else begin
      ret_vld <= fifo_rd_en_a;
      if (fifo_rd_en_a) begin
        fifo_dout <= fmem[rd_ptr].d;
        fifo_sof  <= fmem[rd_ptr].sof;
        fifo_eof  <= fmem[rd_ptr].eof;
        ret_drop  <= fmem[rd_ptr].drop;
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  // Occupancy tracker: beats read and not yet handed off or dropped.
  logic hs_a;
  int   occ = 0;
  int   viol = 0;
  assign hs_a = a_if.out_valid && out_ready;
  always @(posedge rd_clk) begin
    if (reset) begin
      occ <= 0;
    end else begin
      if (fifo_rd_en_a && (occ - int'(hs_a)) >= 2) viol <= viol + 1;
      occ <= occ + int'(fifo_rd_en_a) - int'(hs_a) - int'(ret_vld && ret_drop);
    end
  end

  // Scoreboard and counters
  typedef struct packed { logic [7:0] d; logic sof; logic eof; logic [15:0] len; } exp_t;
  exp_t exp_q [$];
  int n_chk = 0, n_fail = 0;
  int exp_ns = 0, exp_sif = 0, exp_tla = 0, exp_tlb = 0, exp_frames = 0;
  int obs_ns = 0, obs_sif = 0, obs_tla = 0, obs_tlb = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(negedge rd_clk) begin
    if (!reset) begin
      if (err_no_sof_a)       obs_ns++;
      if (err_sof_in_frame_a) obs_sif++;
      if (err_too_long_a)     obs_tla++;
      if (err_too_long_b)     obs_tlb++;
      if (a_if.out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {56'd0, a_if.out_data}, 64'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("a_data", a_if.out_data, e.d);
          chk("a_tags", {a_if.out_sof, a_if.out_eof}, {e.sof, e.eof});
          if (e.eof) chk("a_len", a_if.out_len, mn(int'(e.len), MAX_A));
          chk("b_beat", {b_if.out_valid, b_if.out_data, b_if.out_sof, b_if.out_eof},
              {1'b1, e.d, e.sof, e.eof});
          if (e.eof) chk("b_len", b_if.out_len, mn(int'(e.len), MAX_B));
        end
      end
    end
  end

  task automatic push_beat(input logic [7:0] d, input logic sof, input logic eof,
                           input logic fwd, input int len,
                           input logic e_ns, input logic e_sif, input logic e_tlb);
    fmem[wr_ptr] = '{d, sof, eof, !fwd};
    wr_ptr = wr_ptr + 1;
    if (fwd) begin
      exp_q.push_back('{d, sof, eof, 16'(len)});
      if (eof) exp_frames++;
    end
    exp_ns  += int'(e_ns);
    exp_sif += int'(e_sif);
    exp_tlb += int'(e_tlb);
  endtask

  task automatic drain(input string tag, input bit rand_ready);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_ptr != wr_ptr) && n < 3000) begin
      @(posedge rd_clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    repeat (4) @(posedge rd_clk);
    #1;
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_no_sof"},   obs_ns,  exp_ns);
    chk({tag, "_sof_in"},   obs_sif, exp_sif);
    chk({tag, "_tl_a"},     obs_tla, exp_tla);
    chk({tag, "_tl_b"},     obs_tlb, exp_tlb);
    chk({tag, "_frames_a"}, frame_count_a, exp_frames);
    chk({tag, "_frames_b"}, frame_count_b, exp_frames);
  endtask

  typedef struct {
    int grp; logic [7:0] d; logic sof; logic eof; logic fwd; int len;
    logic ns; logic sif; logic tlb;
  } vec_t;
  vec_t vt [21];

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //       grp data  sof   eof   fwd   len ns    sif   tlb
    vt = '{
      '{0, 8'h11, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0},
      '{0, 8'h22, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0},
      '{0, 8'h33, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0},
      '{1, 8'hA5, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0},
      '{1, 8'h5A, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0},
      '{2, 8'h01, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0},
      '{2, 8'h02, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0},
      '{2, 8'h10, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0},
      '{2, 8'h20, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0},
      '{3, 8'h10, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0},
      '{3, 8'h20, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0},
      '{3, 8'h30, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0},
      '{3, 8'h40, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0},
      '{4, 8'h61, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0},
      '{4, 8'h62, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0},
      '{4, 8'h63, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0},
      '{4, 8'h64, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0},
      '{4, 8'h65, 1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b1},
      '{4, 8'h66, 1'b0, 1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0},
      '{5, 8'h70, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0},
      '{5, 8'h71, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0}
    };

    // Reset state
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk);
    chk("rst_rd_en", fifo_rd_en_a, 0);
    chk("rst_out", {a_if.out_valid, a_if.out_data, a_if.out_sof, a_if.out_eof, a_if.out_len}, 0);
    chk("rst_err", {err_no_sof_a, err_sof_in_frame_a, err_too_long_a}, 0);
    chk("rst_frames", frame_count_a, 0);
    @(posedge rd_clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;

    // Table-driven frames
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < 21; i++)
        if (vt[i].grp == g)
          push_beat(vt[i].d, vt[i].sof, vt[i].eof, vt[i].fwd, vt[i].len,
                    vt[i].ns, vt[i].sif, vt[i].tlb);
      drain($sformatf("grp%0d", g), 1'b0);
      check_counts($sformatf("grp%0d", g));
    end

    // Latency and hold under stall
    out_ready = 1'b0;
    @(posedge rd_clk); #1;
    push_beat(8'h77, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    @(negedge rd_clk);
    chk("lat_rd_en_n", fifo_rd_en_a, 1);
    chk("lat_valid_n", a_if.out_valid, 0);
    @(negedge rd_clk);
    chk("lat_valid_n1", a_if.out_valid, 0);
    @(negedge rd_clk);
    chk("lat_valid_n2", {a_if.out_valid, a_if.out_data}, {1'b1, 8'h77});
    @(negedge rd_clk);
    chk("lat_hold_n3", {a_if.out_valid, a_if.out_data, a_if.out_sof, a_if.out_eof},
        {1'b1, 8'h77, 1'b1, 1'b1});
    @(posedge rd_clk); #1;
    out_ready = 1'b1;
    drain("lat", 1'b0);

    // Error pulse timing: dropped beat, pulse exactly two cycles after push
    @(posedge rd_clk); #1;
    push_beat(8'h5B, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    @(negedge rd_clk);
    chk("errt_n", err_no_sof_a, 0);
    @(negedge rd_clk);
    chk("errt_n1", err_no_sof_a, 0);
    @(negedge rd_clk);
    chk("errt_n2", {err_no_sof_a, a_if.out_valid}, {1'b1, 1'b0});
    @(negedge rd_clk);
    chk("errt_n3", err_no_sof_a, 0);
    drain("errt", 1'b0);
    check_counts("errt");

    // Backpressure: only two beats leave the FIFO while stalled
    out_ready = 1'b0;
    begin
      int rd0;
      rd0 = rd_ptr;
      for (int i = 0; i < 5; i++)
        push_beat(8'h80 + 8'(i), i == 0, i == 4, 1'b1, i + 1, 1'b0, 1'b0, i == 4);
      repeat (10) @(posedge rd_clk);
      #1;
      chk("stall_reads", rd_ptr - rd0, 2);
      chk("stall_rd_en", {fifo_empty, fifo_rd_en_a}, 2'b00);
    end
    out_ready = 1'b1;
    drain("stall", 1'b0);
    check_counts("stall");

    // 64-beat frame with random backpressure
    for (int i = 0; i < 64; i++)
      push_beat(8'($urandom_range(0, 255)), i == 0, i == 63, 1'b1, i + 1,
                1'b0, 1'b0, i == 4);
    drain("rand64", 1'b1);
    check_counts("rand64");
    chk("credit_viol", viol, 0);

    // Reset mid-frame
    out_ready = 1'b0;
    push_beat(8'hB1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    push_beat(8'hB2, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
    push_beat(8'hB3, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge rd_clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_frames = 0;
    @(posedge rd_clk); #1;
    reset = 1'b0;
    @(negedge rd_clk);
    chk("mrst_out", {a_if.out_valid, a_if.out_data, a_if.out_sof, a_if.out_eof, a_if.out_len}, 0);
    chk("mrst_err", {err_no_sof_a, err_sof_in_frame_a, err_too_long_a}, 0);
    chk("mrst_frames", frame_count_a, 0);
    @(posedge rd_clk); #1;
    out_ready = 1'b1;
    push_beat(8'hC1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    push_beat(8'hC2, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
    push_beat(8'hC3, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    drain("mrst", 1'b0);
    check_counts("mrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/udp_frame_reader.md
# udp_frame_reader

Read-side drain engine for the framed byte FIFO pair in the UDP receive path. Pulls bytes with their sof/eof tags from the FIFO read port, hides the FIFO's one-cycle read latency behind a 2-entry skid buffer, and presents a valid/ready byte stream to the UDP parser. It checks framing, drops bytes outside a frame, and reports per-frame length and error events. Runs entirely in the FIFO read clock domain.

## Interface
- DATA_WIDTH, 8, byte lane width; matches FIFO data width
- MAX_FRAME_LEN, 2048, frame length limit in beats; longer frames are flagged
- LEN_WIDTH, $clog2(MAX_FRAME_LEN+1), width of the length output

Single clock; reset is synchronous and active-high.
- rd_clk  in  1  sole clock (FIFO read clock)
- reset  in  1  synchronous, active-high
- fifo_rd_en  out  1  read strobe to FIFO
- fifo_dout  in  DATA_WIDTH  FIFO data, valid the cycle after fifo_rd_en
- fifo_sof  in  1  start-of-frame tag, same timing as fifo_dout
- fifo_eof  in  1  end-of-frame tag, same timing as fifo_dout
- fifo_empty  in  1  FIFO empty
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  DATA_WIDTH  beat data
- out_sof  out  1  first beat of frame
- out_eof  out  1  last beat of frame
- out_len  out  LEN_WIDTH  beats in frame including this one; meaningful with out_eof; saturates at MAX_FRAME_LEN
- err_no_sof  out  1  one-cycle pulse: byte dropped outside a frame
- err_sof_in_frame  out  1  one-cycle pulse: sof arrived before eof of the current frame
- err_too_long  out  1  one-cycle pulse: frame beat MAX_FRAME_LEN+1 forwarded
- frame_count  out  16  completed frames (eof accepted), wraps

## Operation
- fifo_rd_en = !fifo_empty && (entries + inflight < 2) && !reset. inflight is a 1-bit register set on fifo_rd_en. entries is skid occupancy (0..2).
- Return beat (inflight high) goes through the framing FSM, then into the skid buffer if forwarded.
- The FSM has two states: IDLE and IN_FRAME. Reset enters IDLE.
- In IDLE:
  - A sof beat is forwarded with out_sof=1. The FSM moves to IN_FRAME unless eof is also set (1-beat frame, length 1).
  - A non-sof beat is dropped and pulses err_no_sof. The state is unchanged.
- In IN_FRAME:
  - A non-sof beat is forwarded. eof returns the FSM to IDLE.
  - A sof beat pulses err_sof_in_frame. It is forwarded as the start of a new frame, and the length restarts at 1. The previous frame never shows out_eof.
- Length counter: set to 1 on sof, incremented per forwarded beat, saturating at MAX_FRAME_LEN. It is captured with the beat into the skid entry. err_too_long pulses exactly once per frame, on the first beat past the limit.
- frame_count increments when the out_eof beat is handshaken (out_valid && out_ready), not when it is read from the FIFO.
- Skid buffer:
  - FIFO order is preserved, with push and pop in the same cycle allowed.
  - Outputs come straight from the head register. No combinational path runs from out_ready to out_valid or out_data.
  - out_ready may gate fifo_rd_en combinationally through entries.

## Timing
- Reset values: fifo_rd_en 0, out_valid 0, out_data/out_sof/out_eof/out_len 0, all err_* 0, frame_count 0, inflight 0, entries 0, state IDLE.
- Latency: fifo_empty falls in cycle N, so fifo_rd_en=1 in N, the beat is captured at the end of N+1, and out_valid=1 in N+2.
- Throughput: 1 beat/cycle sustained while out_ready=1 and the FIFO is non-empty.
- Backpressure: with out_ready=0, at most 2 beats are held. fifo_rd_en stays low once entries+inflight=2. No beat is lost or duplicated.
- out_valid, once high, stays high with stable data and tags until handshaken.
- Error pulses are asserted in the cycle after the offending beat's return cycle (registered). Dropped beats never reach out_valid.
- Reset asserted mid-operation:
  - All state clears in the next cycle.
  - A read returning in the reset cycle, or the cycle after, is discarded, because inflight clears.
  - A partial frame is abandoned without eof. The FIFO shares the same reset.

## Structure
- Package udp_pkg holds:
  - the FSM state enum (FR_IDLE, FR_IN_FRAME);
  - a packed beat struct {data, sof, eof, len};
  - the DATA_WIDTH default constant.
- One sub-module, udp_skid_buf2: a 2-entry valid/ready register buffer, parameterised on payload width, carrying the packed beat.
- The framing FSM, length counter, read-credit logic and counters stay in udp_frame_reader.

## Test plan
- Frame 0x11(sof),0x22,0x33(eof) with out_ready=1 → 3 beats in consecutive cycles, out_sof on 0x11, out_eof on 0x33 with out_len=3, frame_count=1.
- Single beat 0xA5 with sof=eof=1 → one beat with out_sof=out_eof=1, out_len=1, FSM remains IDLE.
- Beats 0x01,0x02 with no sof, then 0x10(sof),0x20(eof) → 2 err_no_sof pulses, only 0x10 and 0x20 are output.
- 0x10(sof),0x20, then 0x30(sof),0x40(eof) → one err_sof_in_frame pulse, 4 beats output, out_len=2 on 0x40, frame_count=1.
- 64-beat frame, out_ready toggled randomly at 50% → exact order and tags preserved, fifo_rd_en never asserted with entries+inflight=2, no beat lost.
- MAX_FRAME_LEN=4, 6-beat frame → err_too_long pulses once on beat 5, out_len=4 on the eof beat. Separately, reset asserted mid-frame → all outputs 0 next cycle, and the next frame is delivered cleanly.
